edge_detect_multi: RTL and testbench

EDGE_DETECT_MULTI -- requirements
Module: edge_detect_multi

---
 rtl/edge_detect_multi.sv | 125 ++++++++++++
 tb/tb_edge_detect_multi.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_multi.sv
// edge_detect_multi: multi-channel edge detector with optional input synchronizers,
// per-channel rise/fall/both mode selection, sticky "edge seen" flags and
// saturating per-channel event counters with a selectable readout.
//
// Ports:
//   clk           rising-edge clock for all state
//   rst_n         synchronous active-low reset
//   data_in       monitored levels, one bit per channel (may be asynchronous)
//   mode_i        per channel n, bits [2n+1:2n]: 00 off, 01 rise, 10 fall, 11 both
//   sticky_clr_i  per-channel sticky flag clear
//   cnt_clr_i     clears all event counters
//   cnt_sel_i     channel whose counter drives cnt_o / cnt_sat_o
//   edge_o        registered one-cycle pulse per detected edge
//   any_edge_o    registered OR of all edge conditions
//   sticky_o      per-channel latched edge-seen flags
//   cnt_o         event count of the selected channel (0 if out of range)
//   cnt_sat_o     selected counter is all-ones
module edge_detect_multi #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [2*WIDTH-1:0]   mode_i,
  input  logic [WIDTH-1:0]     sticky_clr_i,
  input  logic                 cnt_clr_i,
  input  logic [4:0]           cnt_sel_i,
  output logic [WIDTH-1:0]     edge_o,
  output logic                 any_edge_o,
  output logic [WIDTH-1:0]     sticky_o,
  output logic [CNT_W-1:0]     cnt_o,
  output logic                 cnt_sat_o
);

  logic [WIDTH-1:0] sync_s;     // synchronized level per channel
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_d, edge_q;
  logic             any_edge_q;
  logic [WIDTH-1:0] sticky_d, sticky_q;
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [CNT_W-1:0] cnt_q [WIDTH];

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_s = data_in;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
          end
        end else begin
          sync_q[0] <= data_in;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign sync_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Edge conditions, sticky and counter next-state. Mode only gates the
  // detection terms; history keeps tracking the input regardless of mode.
  always_comb begin
    edge_d   = '0;
    sticky_d = sticky_q;
    for (int unsigned n = 0; n < WIDTH; n++) begin
      edge_d[n] = (mode_i[2*n]   &  sync_s[n] & ~prev_q[n]) |
                  (mode_i[2*n+1] & ~sync_s[n] &  prev_q[n]);
    end
    // Set wins over a simultaneous clear.
    sticky_d = (sticky_q & ~sticky_clr_i) | edge_d;
    for (int unsigned n = 0; n < WIDTH; n++) begin
      cnt_d[n] = cnt_q[n];
      if (cnt_clr_i) begin
        cnt_d[n] = '0;
      end else if (edge_d[n] && (cnt_q[n] != {CNT_W{1'b1}})) begin
        cnt_d[n] = cnt_q[n] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q     <= '0;
      edge_q     <= '0;
      any_edge_q <= 1'b0;
      sticky_q   <= '0;
      for (int unsigned n = 0; n < WIDTH; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      prev_q     <= sync_s;
      edge_q     <= edge_d;
      any_edge_q <= |edge_d;
      sticky_q   <= sticky_d;
      for (int unsigned n = 0; n < WIDTH; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  // Readout mux; an out-of-range select matches no channel and reads zero.
  always_comb begin
    cnt_o     = '0;
    cnt_sat_o = 1'b0;
    for (int unsigned n = 0; n < WIDTH; n++) begin
      if (cnt_sel_i == 5'(n)) begin
        cnt_o     = cnt_q[n];
        cnt_sat_o = &cnt_q[n];
      end
    end
  end

  assign edge_o     = edge_q;
  assign any_edge_o = any_edge_q;
  assign sticky_o   = sticky_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi (WIDTH=4, SYNC_STAGES=2, CNT_W=2).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_edge_detect_multi;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic [2*W-1:0] mode_i;
  logic [W-1:0] sticky_clr_i;
  logic         cnt_clr_i;
  logic [4:0]   cnt_sel_i;
  logic [W-1:0] edge_o;
  logic         any_edge_o;
  logic [W-1:0] sticky_o;
  logic [1:0]   cnt_o;
  logic         cnt_sat_o;

  int passed = 0;
  int total  = 0;

  edge_detect_multi #(
    .WIDTH      (4),
    .SYNC_STAGES(2),
    .CNT_W      (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .mode_i      (mode_i),
    .sticky_clr_i(sticky_clr_i),
    .cnt_clr_i   (cnt_clr_i),
    .cnt_sel_i   (cnt_sel_i),
    .edge_o      (edge_o),
    .any_edge_o  (any_edge_o),
    .sticky_o    (sticky_o),
    .cnt_o       (cnt_o),
    .cnt_sat_o   (cnt_sat_o)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_cnt(input string tag, input logic [4:0] sel, input logic [31:0] exp_cnt,
                         input logic [31:0] exp_sat);
    cnt_sel_i = sel;
    #1;
    chk({tag, "_cnt"}, 32'(cnt_o), exp_cnt);
    chk({tag, "_sat"}, 32'(cnt_sat_o), exp_sat);
  endtask

  initial begin
    rst_n        = 1'b0;
    data_in      = '0;
    mode_i       = '0;
    sticky_clr_i = '0;
    cnt_clr_i    = 1'b0;
    cnt_sel_i    = '0;

    // Reset state
    step(2);
    chk("rst_edge", 32'(edge_o), 0);
    chk("rst_any", 32'(any_edge_o), 0);
    chk("rst_sticky", 32'(sticky_o), 0);
    chk_cnt("rst", 5'd0, 0, 0);
    rst_n = 1'b1;
    step(3);
    chk("idle_edge", 32'(edge_o), 0);

    // Rising edge on ch0, latency SYNC_STAGES+1
    mode_i     = 8'h01;
    data_in[0] = 1'b1;
    step(2);
    chk("r0_early", 32'(edge_o), 0);
    step(1);
    chk("r0_edge", 32'(edge_o), 32'h1);
    chk("r0_any", 32'(any_edge_o), 1);
    chk("r0_sticky", 32'(sticky_o), 32'h1);
    chk_cnt("r0", 5'd0, 1, 0);
    step(1);
    chk("r0_after", 32'(edge_o), 0);
    chk("r0_any_after", 32'(any_edge_o), 0);

    // Both-edge mode on ch1, 5-cycle pulse
    mode_i     = 8'h0D;
    data_in[1] = 1'b1;
    step(3);
    chk("b1_rise", 32'(edge_o), 32'h2);
    step(1);
    chk("b1_gap", 32'(edge_o), 0);
    step(1);
    data_in[1] = 1'b0;
    step(2);
    chk("b1_gap2", 32'(edge_o), 0);
    step(1);
    chk("b1_fall", 32'(edge_o), 32'h2);
    step(1);
    chk("b1_after", 32'(edge_o), 0);
    chk_cnt("b1", 5'd1, 2, 0);
    chk("b1_sticky", 32'(sticky_o), 32'h3);

    // Same stimulus with ch1 off
    mode_i     = 8'h01;
    data_in[1] = 1'b1;
    step(3);
    chk("off1_rise", 32'(edge_o), 0);
    step(2);
    data_in[1] = 1'b0;
    step(3);
    chk("off1_fall", 32'(edge_o), 0);
    chk("off1_any", 32'(any_edge_o), 0);
    chk_cnt("off1", 5'd1, 2, 0);

    // Sticky set wins over simultaneous clear
    data_in[0] = 1'b0;
    step(4);
    sticky_clr_i = 4'h1;
    step(1);
    sticky_clr_i = 4'h0;
    chk("sc_cleared", 32'(sticky_o), 32'h2);
    data_in[0] = 1'b1;
    step(2);
    sticky_clr_i = 4'h1;
    step(1);
    chk("sc_edge", 32'(edge_o), 32'h1);
    chk("sc_setwins", 32'(sticky_o), 32'h3);
    step(1);
    sticky_clr_i = 4'h0;
    chk("sc_clear_alone", 32'(sticky_o), 32'h2);
    chk_cnt("sc", 5'd0, 2, 0);

    // Saturation on ch2 with 2-bit counters
    mode_i    = 8'h11;
    cnt_clr_i = 1'b1;
    step(1);
    cnt_clr_i = 1'b0;
    chk_cnt("clr0", 5'd0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      data_in[2] = 1'b1;
      step(3);
      chk("sat_edge", 32'(edge_o), 32'h4);
      chk_cnt("sat", 5'd2, (i < 2) ? 32'(i + 1) : 32'd3, (i >= 2) ? 32'd1 : 32'd0);
      data_in[2] = 1'b0;
      step(3);
    end
    cnt_clr_i = 1'b1;
    step(1);
    cnt_clr_i = 1'b0;
    chk_cnt("sat_clr", 5'd2, 0, 0);

    // Clear wins over a simultaneous increment
    data_in[2] = 1'b1;
    step(2);
    cnt_clr_i = 1'b1;
    step(1);
    cnt_clr_i = 1'b0;
    chk("cw_edge", 32'(edge_o), 32'h4);
    chk_cnt("cw", 5'd2, 0, 0);
    data_in[2] = 1'b0;
    step(3);
    chk_cnt("cw_fall", 5'd2, 0, 0);

    // All channels toggle together in both-edge mode
    data_in = 4'h0;
    step(4);
    mode_i    = 8'hFF;
    cnt_clr_i = 1'b1;
    step(1);
    cnt_clr_i = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      data_in = (j % 2 == 1) ? 4'hF : 4'h0;
      step(3);
      chk("all_edge", 32'(edge_o), 32'hF);
      chk("all_any", 32'(any_edge_o), 1);
      for (int c = 0; c < 4; c++) begin
        chk_cnt("all", 5'(c), 32'(j), (j == 3) ? 32'd1 : 32'd0);
      end
      step(1);
      chk("all_gap", 32'(edge_o), 0);
    end
    chk("all_sticky", 32'(sticky_o), 32'hF);
    chk_cnt("sel_oor", 5'd4, 0, 0);

    // Reset mid-stream with a falling edge in flight
    data_in = 4'h0;
    step(1);
    rst_n = 1'b0;
    step(1);
    chk("mr_edge", 32'(edge_o), 0);
    chk("mr_any", 32'(any_edge_o), 0);
    chk("mr_sticky", 32'(sticky_o), 0);
    chk_cnt("mr", 5'd0, 0, 0);

    // Input high across reset release: ch0 rise, ch1 fall, ch2 both, ch3 off
    data_in = 4'hF;
    mode_i  = 8'h39;
    step(1);
    rst_n = 1'b1;
    step(2);
    chk("rel_early", 32'(edge_o), 0);
    step(1);
    chk("rel_edge", 32'(edge_o), 32'h5);
    chk("rel_any", 32'(any_edge_o), 1);
    step(1);
    chk("rel_after", 32'(edge_o), 0);
    step(4);
    chk("rel_quiet", 32'(edge_o), 0);
    chk("rel_quiet_any", 32'(any_edge_o), 0);
    chk("rel_sticky", 32'(sticky_o), 32'h5);
    chk_cnt("rel0", 5'd0, 1, 0);
    chk_cnt("rel1", 5'd1, 0, 0);
    chk_cnt("rel2", 5'd2, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
